// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings,
// control-word layout, FSM states and the per-op decode rules.
package serial_alu_pkg;

    // Operation codes presented on the op port; 110/111 are illegal.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101
    } op_e;

    // Layout of the 5-bit control word driven to the 1-bit ALU cell.
    localparam int CTRL_W       = 5;
    localparam int CTRL_FUNC_HI = 4;
    localparam int CTRL_FUNC_LO = 3;
    localparam int CTRL_INV     = 2;
    localparam int CTRL_CIN     = 1;
    localparam int CTRL_SHIFT   = 0;

    // Cell function codes for the [4:3] field.
    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_AND = 2'b10;
    localparam logic [1:0] FUNC_OR  = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True for the six defined op codes.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_NOR;
    endfunction

    // Cell function selected by an op; nand/nor reuse and/or plus invert.
    function automatic logic [1:0] op_func(input logic [2:0] op);
        logic [1:0] f;
        f = FUNC_ADD;
        case (op)
            OP_ADD:          f = FUNC_ADD;
            OP_SUB:          f = FUNC_SUB;
            OP_AND, OP_NAND: f = FUNC_AND;
            OP_OR,  OP_NOR:  f = FUNC_OR;
            default:         f = FUNC_ADD;
        endcase
        return f;
    endfunction

    // Output-invert bit for nand/nor.
    function automatic logic op_inv(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR);
    endfunction

    // Carry-chain rule: only arithmetic ops propagate carry/borrow between bits.
    function automatic logic op_uses_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving a 1-bit ALU cell LSB first. Latches the
// operands on an accepted start, walks one bit per clock while feeding the
// registered carry/borrow back into the cell, then assembles the result,
// final carry/borrow and zero flag and pulses done for one cycle.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              zero,
    output logic              alu_a,
    output logic              alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic              alu_out,
    input  logic              alu_cy
);

    localparam int              IW       = $clog2(WIDTH);
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, result_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             cy_q, carry_q, err_q, busy_q;

    logic             accept_legal, accept_illegal, last_bit;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and cell drive; the cell sees an all-zero word outside RUN.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        last_bit       = 1'b0;
        alu_a          = 1'b0;
        alu_b          = 1'b0;
        alu_ctrl       = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_legal(op)) begin
                        accept_legal = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        accept_illegal = 1'b1;
                        state_d        = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                alu_a                                = opa_q[idx_q];
                alu_b                                = opb_q[idx_q];
                alu_ctrl[CTRL_FUNC_HI:CTRL_FUNC_LO]  = op_func(op_q);
                alu_ctrl[CTRL_INV]                   = op_inv(op_q);
                alu_ctrl[CTRL_CIN]                   = cy_q;
                alu_ctrl[CTRL_SHIFT]                 = 1'b0;
                last_bit                             = (idx_q == LAST_IDX);
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, bit walk, carry chain and result/flag assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (accept_legal) begin
            opa_q    <= opa;
            opb_q    <= opb;
            op_q     <= op;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else if (accept_illegal) begin
            // Operands are left untouched; the op never reaches the cell.
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b1;
        end else if (state_q == ST_RUN) begin
            result_q[idx_q] <= alu_out;
            cy_q            <= op_uses_carry(op_q) ? alu_cy : 1'b0;
            if (last_bit) carry_q <= op_uses_carry(op_q) ? alu_cy : 1'b0;
            else          idx_q   <= idx_q + 1'b1;
        end else if (state_q == ST_DONE) begin
            busy_q <= 1'b0;
        end
    end

    assign busy   = busy_q;
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: a behavioural 1-bit ALU cell closes
// the loop, and expected results come from whole-word arithmetic.
module tb_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] opa = '0, opb = '0;
    logic         busy, done, err, carry, zero;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_out, alu_cy;
    logic [4:0]   alu_ctrl;

    int checks = 0;
    int errors = 0;

    // Observations captured by exec_op.
    int           obs_done_cyc, obs_done_cnt, obs_busy_last, obs_busy_cnt, obs_proto_bad;
    logic [W-1:0] obs_result, obs_end_result;
    logic         obs_carry, obs_zero, obs_err, obs_end_carry;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .err(err), .result(result), .carry(carry),
        .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_cy(alu_cy)
    );

    // Behavioural 1-bit cell: integer arithmetic on single bits.
    always_comb begin
        int t;
        t       = 0;
        alu_out = 1'b0;
        alu_cy  = 1'b0;
        case (alu_ctrl[4:3])
            2'b00: begin
                t = int'(alu_a) + int'(alu_b) + int'(alu_ctrl[1]);
                alu_out = t[0];
                alu_cy  = (t > 1);
            end
            2'b01: begin
                t = int'(alu_a) - int'(alu_b) - int'(alu_ctrl[1]);
                alu_out = t[0];
                alu_cy  = (t < 0);
            end
            2'b10:   alu_out = (alu_a & alu_b) ^ alu_ctrl[2];
            default: alu_out = (alu_a | alu_b) ^ alu_ctrl[2];
        endcase
    end

    // Whole-word reference for one operation.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic e);
        longint sa, sb, s;
        sa = longint'(a);
        sb = longint'(b);
        s  = 0;
        r = '0; c = 1'b0; e = 1'b0;
        case (o)
            3'd0: begin s = sa + sb; r = W'(s); c = (s >= (longint'(1) << W)); end
            3'd1: begin s = sa - sb + (longint'(1) << W); r = W'(s); c = (sa < sb); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            default: e = 1'b1;
        endcase
    endfunction

    // Carry (add) or borrow (sub) entering bit i, from the low i bits of the operands.
    function automatic logic chain_in(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        longint m, la, lb;
        m  = (longint'(1) << i) - 1;
        la = longint'(a) & m;
        lb = longint'(b) & m;
        if (o == 3'd0) return ((la + lb) >> i) != 0;
        if (o == 3'd1) return la < lb;
        return 1'b0;
    endfunction

    // Drives one start (entered from anywhere, launched on a falling edge) and
    // observes WIDTH+4 cycles; optionally pulses stray starts during RUN and DONE.
    task automatic exec_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic       legal;
        logic [1:0] f;
        legal = (o < 3'd6);
        f = (o == 3'd0) ? 2'b00 : (o == 3'd1) ? 2'b01 : (o == 3'd2 || o == 3'd4) ? 2'b10 : 2'b11;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_last = 0; obs_busy_cnt = 0; obs_proto_bad = 0;
        for (int cyc = 1; cyc <= W + 4; cyc++) begin
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = cyc;
                    obs_result = result; obs_carry = carry; obs_zero = zero; obs_err = err;
                end
            end
            if (busy === 1'b1) begin
                obs_busy_last = cyc;
                obs_busy_cnt++;
            end
            if (legal && cyc <= W) begin
                if (alu_a !== a[cyc-1] || alu_b !== b[cyc-1] || alu_ctrl[4:3] !== f ||
                    alu_ctrl[2] !== (o == 3'd4 || o == 3'd5) || alu_ctrl[0] !== 1'b0 ||
                    alu_ctrl[1] !== chain_in(o, a, b, cyc - 1))
                    obs_proto_bad++;
            end else if (alu_ctrl !== 5'b0 || alu_a !== 1'b0 || alu_b !== 1'b0) begin
                obs_proto_bad++;
            end
            if (inject && (cyc == 3 || cyc == W + 1)) begin
                start = 1'b1; op = 3'($urandom_range(0, 5));
                opa = W'($urandom); opb = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        obs_end_result = result;
        obs_end_carry  = carry;
    endtask

    // Runs one op and compares every observation against the reference.
    task automatic test_one(input string name, input logic [2:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit inject);
        logic [W-1:0] er;
        logic         ec, ee;
        int           exp_done, exp_busy;
        model(o, a, b, er, ec, ee);
        exp_done = ee ? 1 : W + 1;
        exp_busy = exp_done;
        exec_op(o, a, b, inject);
        checks++; if (obs_done_cyc !== exp_done) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", name, obs_done_cyc, exp_done); end
        checks++; if (obs_done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, obs_done_cnt); end
        checks++; if (obs_busy_last !== exp_busy || obs_busy_cnt !== exp_busy) begin errors++; $display("FAIL %s busy_span got last %0d cnt %0d want %0d", name, obs_busy_last, obs_busy_cnt, exp_busy); end
        checks++; if (obs_result !== er) begin errors++; $display("FAIL %s result got %h want %h", name, obs_result, er); end
        checks++; if (obs_carry !== ec) begin errors++; $display("FAIL %s carry got %b want %b", name, obs_carry, ec); end
        checks++; if (obs_zero !== (er == '0)) begin errors++; $display("FAIL %s zero got %b want %b", name, obs_zero, (er == '0)); end
        checks++; if (obs_err !== ee) begin errors++; $display("FAIL %s err got %b want %b", name, obs_err, ee); end
        checks++; if (obs_proto_bad !== 0) begin errors++; $display("FAIL %s cell_drive bad_cycles %0d want 0", name, obs_proto_bad); end
        checks++; if (obs_end_result !== er || obs_end_carry !== ec) begin errors++; $display("FAIL %s hold got %h/%b want %h/%b", name, obs_end_result, obs_end_carry, er, ec); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, err, carry, zero} !== 5'b00001) begin errors++; $display("FAIL reset flags got %b want 00001", {busy, done, err, carry, zero}); end
        checks++; if (result !== '0 || alu_ctrl !== 5'b0 || alu_a !== 1'b0 || alu_b !== 1'b0) begin errors++; $display("FAIL reset data got %h/%b/%b%b want 0", result, alu_ctrl, alu_a, alu_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        test_one("add_5a_3c", 3'd0, 8'h5A, 8'h3C, 1'b0);
        checks++; if (obs_result !== 8'h96 || obs_carry !== 1'b0 || obs_zero !== 1'b0) begin errors++; $display("FAIL add_5a_3c_const got %h/%b/%b want 96/0/0", obs_result, obs_carry, obs_zero); end
        test_one("add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0);
        checks++; if (obs_result !== 8'h00 || obs_carry !== 1'b1 || obs_zero !== 1'b1) begin errors++; $display("FAIL add_ff_01_const got %h/%b/%b want 00/1/1", obs_result, obs_carry, obs_zero); end
    endtask

    task automatic test_sub;
        test_one("sub_10_20", 3'd1, 8'h10, 8'h20, 1'b0);
        checks++; if (obs_result !== 8'hF0 || obs_carry !== 1'b1) begin errors++; $display("FAIL sub_10_20_const got %h/%b want f0/1", obs_result, obs_carry); end
        test_one("sub_33_33", 3'd1, 8'h33, 8'h33, 1'b0);
        checks++; if (obs_result !== 8'h00 || obs_carry !== 1'b0 || obs_zero !== 1'b1) begin errors++; $display("FAIL sub_33_33_const got %h/%b/%b want 00/0/1", obs_result, obs_carry, obs_zero); end
    endtask

    task automatic test_logic;
        logic [W-1:0] want [4];
        want[0] = 8'hC0; want[1] = 8'hFC; want[2] = 8'h3F; want[3] = 8'h03;
        for (int k = 0; k < 4; k++) begin
            test_one($sformatf("logic_op%0d", k + 2), 3'(k + 2), 8'hF0, 8'hCC, 1'b0);
            checks++; if (obs_result !== want[k] || obs_carry !== 1'b0) begin errors++; $display("FAIL logic_op%0d_const got %h/%b want %h/0", k + 2, obs_result, obs_carry, want[k]); end
        end
    endtask

    task automatic test_ignored_start;
        test_one("stray_start", 3'd0, 8'h5A, 8'h3C, 1'b1);
        test_one("after_stray", 3'd1, 8'h81, 8'h7F, 1'b0);
    endtask

    task automatic test_illegal;
        test_one("illegal_110", 3'd6, 8'h12, 8'h34, 1'b0);
        test_one("illegal_111", 3'd7, 8'hFF, 8'hFF, 1'b0);
        test_one("clear_err", 3'd0, 8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 8'h5A; opb = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (alu_ctrl[1] !== chain_in(3'd0, 8'h5A, 8'hC3, 3)) begin errors++; $display("FAIL midrun_cin got %b want %b", alu_ctrl[1], chain_in(3'd0, 8'h5A, 8'hC3, 3)); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, err, carry, zero} !== 5'b00001 || result !== '0) begin errors++; $display("FAIL midrun_reset got %b/%h want 00001/00", {busy, done, err, carry, zero}, result); end
        checks++; if (alu_ctrl !== 5'b0 || alu_a !== 1'b0 || alu_b !== 1'b0) begin errors++; $display("FAIL midrun_reset_cell got %b/%b%b want 0", alu_ctrl, alu_a, alu_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || alu_ctrl !== 5'b0) begin errors++; $display("FAIL midrun_idle got %b%b/%b want 00/0", busy, done, alu_ctrl); end
        test_one("post_reset_add", 3'd0, 8'h01, 8'h02, 1'b0);
        checks++; if (obs_result !== 8'h03 || obs_carry !== 1'b0) begin errors++; $display("FAIL post_reset_const got %h/%b want 03/0", obs_result, obs_carry); end
    endtask

    task automatic test_random;
        logic [2:0] o;
        for (int n = 0; n < 40; n++) begin
            o = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            test_one($sformatf("rand%0d", n), o, W'($urandom), W'($urandom),
                     (o < 3'd6) && ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignored_start();
        test_illegal();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
